// File: rtl/mips_pkg.sv
// mips_pkg: shared Mini MIPS types and constants
package mips_pkg;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {MDU_MULTU = 2'd0, MDU_DIVU = 2'd1, MDU_MTHI = 2'd2, MDU_MTLO = 2'd3} mdu_op_e;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} mdu_state_e;
endpackage

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative unsigned multiply/divide unit with HI/LO registers
module mdu_hilo
  import mips_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  mdu_state_e state, state_n;
  mdu_op_e op_q;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] d;
  logic [WIDTH:0] msum, rsh;
  logic [WIDTH+1:0] diff;
  logic accept, last, iter;
  assign accept = start && state != BUSY;
  assign last = state == BUSY && cnt == CW'(WIDTH - 1);
  assign iter = !op[1];
  assign busy = state == BUSY;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    if (accept) state_n = iter ? BUSY : IDLE;
    else if (last) state_n = DONE;
    else if (state == DONE) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // acc holds {partial product, multiplier} for MULTU and {remainder, quotient} for DIVU
  always_comb begin
    msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, d} : '0);
    rsh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff = {1'b0, rsh} - {2'b0, d};
    acc_n = op_q == MDU_MULTU ? {msum, acc[WIDTH-1:1]}
          : diff[WIDTH+1] ? {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
          : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q <= MDU_MULTU;
      cnt <= '0;
      acc <= '0;
      d <= '0;
      hi <= '0;
      lo <= '0;
    end else if (accept) begin
      if (iter) begin
        op_q <= mdu_op_e'(op);
        cnt <= '0;
        acc <= {{WIDTH{1'b0}}, op == MDU_MULTU ? b : a};
        d <= op == MDU_MULTU ? a : b;
      end else if (op == MDU_MTHI) hi <= a;
      else lo <= a;
    end else if (state == BUSY) begin
      acc <= acc_n;
      cnt <= cnt + CW'(1);
      if (last) {hi, lo} <= acc_n;
    end
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: table-driven, directed and random checks of mdu_hilo against a reference model
module tb_mdu_hilo;
  logic clk = 0, rst_n = 0, start = 0;
  logic [1:0] op = 0;
  logic [31:0] a = 0, b = 0;
  logic busy, done;
  logic [31:0] hi, lo;
  int nvec = 0, nmis = 0;
  logic [31:0] rh = 0, rl = 0;

  mdu_hilo #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
                              .busy(busy), .done(done), .hi(hi), .lo(lo));

  always #5 clk = ~clk;

  typedef struct {logic [1:0] op; logic [31:0] a, b, eh, el;} vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint unsigned p;
    case (o)
      2'd0: begin p = longint'(x) * longint'(y); rh = p[63:32]; rl = p[31:0]; end
      2'd1: if (y == 0) begin rh = x; rl = '1; end else begin rh = x % y; rl = x / y; end
      2'd2: rh = x;
      default: rl = x;
    endcase
  endtask

  // starts at a negedge, returns at the negedge of the done cycle (or after the MT write)
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int inject);
    logic [31:0] ph = rh, pl = rl;
    int n = 0;
    bit hold_bad = 0;
    start = 1; op = o; a = x; b = y;
    @(negedge clk);
    start = 0;
    model(o, x, y);
    if (!o[1]) begin
      while (busy && n < 40) begin
        if (done || hi !== ph || lo !== pl) hold_bad = 1;
        if (n == inject) begin start = 1; op = 2'd3; a = ~x; b = ~y; end
        else start = 0;
        n++;
        @(negedge clk);
      end
      start = 0;
      chk("busy_cycles", 64'(n), 64'd32);
      chk("hold_during_busy", 64'(hold_bad), 64'd0);
      chk("done_pulse", 64'(done), 64'd1);
    end else begin
      chk("mt_no_done", {busy, done}, 64'd0);
    end
    chk("hi", 64'(hi), 64'(rh));
    chk("lo", 64'(lo), 64'(rl));
  endtask

  initial begin
    tbl[0] = '{2'd0, 32'd7, 32'd6, 32'h0, 32'h2A};
    tbl[1] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1};
    tbl[2] = '{2'd1, 32'd100, 32'd7, 32'd2, 32'd14};
    tbl[3] = '{2'd1, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF};
    tbl[4] = '{2'd2, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF};
    tbl[5] = '{2'd3, 32'hCAFEF00D, 32'h0, 32'h12345678, 32'hCAFEF00D};
    repeat (2) @(negedge clk);
    chk("reset_state", {busy, done, hi, lo}, 64'd0);
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, -1);
      chk("tbl_hi", 64'(hi), 64'(tbl[i].eh));
      chk("tbl_lo", 64'(lo), 64'(tbl[i].el));
    end
    // start during BUSY (MTLO with new a/b) must be ignored
    do_op(2'd0, 32'h00012345, 32'h00067890, 5);
    chk("ignored_start_lo", 64'(lo), 64'h00012345 * 64'h00067890 & 64'hFFFFFFFF);
    @(negedge clk);
    chk("done_falls", 64'(done), 64'd0);
    // asynchronous reset in the middle of a DIVU
    start = 1; op = 2'd1; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    rst_n = 0;
    #1;
    chk("async_rst", {busy, done, hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1;
    rh = 0; rl = 0;
    begin
      bit stray = 0;
      repeat (40) begin
        @(negedge clk);
        if (done || busy) stray = 1;
      end
      chk("no_done_after_abort", 64'(stray), 64'd0);
    end
    do_op(2'd0, 32'd3, 32'd3, -1);
    chk("mult_3x3_lo", 64'(lo), 64'd9);
    // random back-to-back traffic; divisors sometimes small or zero
    for (int i = 0; i < 40; i++) begin
      logic [1:0] o = 2'($urandom_range(0, 3));
      logic [31:0] x = $urandom;
      logic [31:0] y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      do_op(o, x, y, -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
